uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised successor to the team's fixed 8-bit UART transmitter.
- Adds a configurable-depth TX FIFO with a valid/ready write interface.
- Adds runtime data length (5..DATA_W bits), five parity modes and 1 or 2 stop bits.
- Frames go out back-to-back on a shared baud_tick strobe, placed between the bus-side register block and the pad.

Parameters:
- DATA_W, 8, maximum data bits per frame (5..9); width of s_data.
- FIFO_DEPTH, 16, TX FIFO entries; power of 2, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- baud_tick  in  1  one-clk pulse per bit period.
- s_valid  in  1  write request.
- s_ready  out  1  FIFO can accept; equals !fifo_full.
- s_data  in  DATA_W  word to send; LSB is sent first.
- cfg_data_bits  in  4  data bits per frame; values outside 5..DATA_W are treated as DATA_W.
- cfg_parity  in  3  000 none, 001 even, 010 odd, 011 mark (1), 100 space (0); 101..111 are treated as none.
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- tx  out  1  serial line; idle high.
- tx_busy  out  1  high while a frame (or break) is on the line.
- fifo_count  out  CNT_W  occupied entries.
- fifo_full  out  1  fifo_count == FIFO_DEPTH.
- fifo_empty  out  1  fifo_count == 0.

Behaviour:
- Reset (async, reset_n low):
  - tx=1, tx_busy=0, state=IDLE.
  - FIFO pointers and fifo_count=0, fifo_empty=1, fifo_full=0.
  - Reset mid-frame aborts the frame immediately; tx goes to 1 asynchronously.
- FIFO:
  - A write occurs on a clk edge with s_valid && s_ready.
  - s_valid while full is ignored; no overwrite.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop happens only on a baud_tick, as listed below.
  - Pointers wrap modulo FIFO_DEPTH.
- Per-frame capture: cfg_* and the popped word are latched at the pop. Config changes mid-frame do not affect the current frame.
- Parity bit, computed over the cfg_data_bits LSBs only:
  - even = XOR of those bits.
  - odd = its inverse.
  - mark = 1, space = 0.
- FSM: the state names the bit currently driven on tx. Transitions and tx updates happen only on clk edges where baud_tick=1, so every bit lasts exactly one tick interval.
  - IDLE: if !fifo_empty, pop, tx<=0, go to START. Otherwise tx stays 1.
  - START: tx<=d[0], idx<=1, go to DATA.
  - DATA: if idx<nbits, tx<=d[idx] and idx++. Else if parity is enabled, tx<=p and go to PARITY. Else tx<=1 and go to STOP1.
  - PARITY: tx<=1, go to STOP1.
  - STOP1: if stop2, go to STOP2 (tx stays 1). Otherwise run end-of-frame handling.
  - STOP2: run end-of-frame handling.
  - End-of-frame handling: if !fifo_empty, pop, tx<=0, go to START (back-to-back, no idle gap). Otherwise go to IDLE.
- tx_busy (registered):
  - Set on the tick that leaves IDLE.
  - Cleared on the tick that enters IDLE.
  - Stays high across back-to-back frames.
- Latency: a word written into an empty FIFO with the FSM in IDLE appears as a start bit on the first baud_tick after the write edge. A tick in the same cycle as the write does not see the word.
- Frame length in ticks: 1 + nbits + (parity?1:0) + (stop2?2:1).
- baud_tick held high for multiple clks is illegal; behaviour in that case is undefined.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - Adds input port break_req (1 bit) and a BREAK state.
  - On a tick in IDLE, or at end-of-frame, break_req=1 has priority over a pop: tx<=0, tx_busy=1, go to BREAK.
  - In BREAK, the first tick with break_req=0 drives tx<=1 and goes to STOP1 with one stop bit. That stop bit is the mark-after-break.
  - The FIFO is untouched during a break.
- When not defined: no port, no state; behaviour is exactly as above.

Test Plan:
- 8N1, write 0xA5, baud_tick every 16 clks -> tx sequence over ticks: 0,1,0,1,0,0,1,0,1,1; tx_busy high for 10 ticks; fifo_count 1->0 at start.
- 7E2, write 0x53 (7 LSBs 1010011, four ones) -> start, 1,1,0,0,1,0,1, parity 0, stop 1, stop 1 -> 11 ticks.
- 5-bit odd, cfg_data_bits=5, data 0x1F -> 5 ones, parity 0; cfg_data_bits=12 -> treated as DATA_W=8.
- Fill FIFO_DEPTH=16 writes with no ticks -> fifo_full=1, s_ready=0; 17th write dropped; 16 frames go back-to-back with no idle tick between stop and next start; tx_busy never drops.
- Assert reset_n low during DATA bit 3 -> tx=1, tx_busy=0, fifo_count=0 immediately; after release, a new write of 0x3C transmits cleanly.
- With UART_TX_BREAK_EN: break_req high for 20 ticks while a word is queued -> tx low for 20 ticks, one stop tick high, then the queued frame is sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a TX FIFO in front of it.
//
// - Write side: valid/ready. A word is accepted on a clk edge where
//   s_valid && s_ready, and s_ready is simply !fifo_full. The writer may hold
//   s_valid high while s_ready is low; the word is taken on the first edge
//   where both are high. Writes that arrive while the FIFO is full are
//   ignored, so nothing is overwritten.
// - Line side: every bit lasts exactly one baud_tick interval. The FSM only
//   moves, and tx only changes, on clk edges where baud_tick is high.
// - Frame format is captured per frame at the pop. The captured fields are
//   data length (5..DATA_W), parity mode and stop-bit count.
// - Optional break generation is compiled in with `define UART_TX_BREAK_EN.
//   This adds the break_req input and a BREAK state.
// - state_dbg exposes the FSM state so checkers can bind to it.

module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_tick,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [3:0]        cfg_data_bits,
  input  logic [2:0]        cfg_parity,
  input  logic              cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic              break_req,
`endif
  output logic              tx,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [2:0]        state_dbg
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Each state names the bit currently being driven on tx.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
`ifdef UART_TX_BREAK_EN
    ,
    BREAK  = 3'd6
`endif
  } state_t;

  // ---------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign fifo_count = count_q;
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign head       = mem[rd_ptr];

  // Storage array. It has no reset because the count and pointers alone
  // decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  // When a push and a pop happen together, the count does not change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Break request (constant low when the feature is not built)
  // ---------------------------------------------------------------------
  logic brk;
`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Frame format decode, applied to the head word at the moment it is popped
  // ---------------------------------------------------------------------
  logic [3:0] eff_bits;
  logic       par_xor;
  logic       par_en_w;
  logic       par_bit_w;

  // A data length outside 5..DATA_W falls back to the full DATA_W.
  always_comb begin
    eff_bits = 4'(DATA_W);
    if ((cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'(DATA_W))) begin
      eff_bits = cfg_data_bits;
    end
  end

  // Parity is computed over the eff_bits LSBs only.
  // Codes 101..111 behave as "no parity".
  always_comb begin
    par_xor   = 1'b0;
    par_en_w  = 1'b0;
    par_bit_w = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(eff_bits)) begin
        par_xor = par_xor ^ head[i];
      end
    end
    case (cfg_parity)
      3'b001:  begin par_en_w = 1'b1; par_bit_w = par_xor;  end
      3'b010:  begin par_en_w = 1'b1; par_bit_w = ~par_xor; end
      3'b011:  begin par_en_w = 1'b1; par_bit_w = 1'b1;     end
      3'b100:  begin par_en_w = 1'b1; par_bit_w = 1'b0;     end
      default: begin par_en_w = 1'b0; par_bit_w = 1'b0;     end
    endcase
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [3:0]        idx;
  logic [3:0]        nbits;
  logic              par_en;
  logic              par_bit;
  logic              stop2_q;
  logic              frame_end;
  logic              load_slot;

  assign state_dbg = state;

  // frame_end marks the last stop bit of a frame, or the mark-after-break.
  // load_slot is a tick on which the FSM may begin something new: a fresh
  // frame, a break, or going idle.
  assign frame_end = ((state == STOP1) && !stop2_q) || (state == STOP2);
  assign load_slot = baud_tick && ((state == IDLE) || frame_end);

  // A word is popped only where the FSM loads a new frame from it.
  // A pending break takes priority over the pop.
  assign pop = load_slot && !brk && !fifo_empty;

  // The frame sequencer. It keeps tx and tx_busy registered and changes
  // them only on baud ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      shreg   <= '0;
      idx     <= '0;
      nbits   <= 4'(DATA_W);
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2_q <= 1'b0;
    end else if (baud_tick) begin
      if (load_slot) begin
        if (brk) begin
`ifdef UART_TX_BREAK_EN
          tx      <= 1'b0;
          tx_busy <= 1'b1;
          state   <= BREAK;
`endif
        end else if (!fifo_empty) begin
          // Capture the word and its format together; later config changes
          // do not reach this frame.
          tx      <= 1'b0;
          tx_busy <= 1'b1;
          state   <= START;
          shreg   <= head;
          nbits   <= eff_bits;
          par_en  <= par_en_w;
          par_bit <= par_bit_w;
          stop2_q <= cfg_stop2;
        end else begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      end else begin
        case (state)
          START: begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            idx   <= 4'd1;
            state <= DATA;
          end
          DATA: begin
            if (idx < nbits) begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
              idx   <= idx + 4'd1;
            end else if (par_en) begin
              tx    <= par_bit;
              state <= PARITY;
            end else begin
              tx    <= 1'b1;
              state <= STOP1;
            end
          end
          PARITY: begin
            tx    <= 1'b1;
            state <= STOP1;
          end
          STOP1: begin
            // This is reached only with two stop bits; single-stop frames
            // end through load_slot.
            tx    <= 1'b1;
            state <= STOP2;
          end
`ifdef UART_TX_BREAK_EN
          BREAK: begin
            // Hold the line low until break_req drops, then send a single
            // stop bit as the mark-after-break.
            if (!brk) begin
              tx      <= 1'b1;
              stop2_q <= 1'b0;
              state   <= STOP1;
            end
          end
`endif
          default: begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo.
// It runs directed frames, then a randomized soak.
// A queue-based model of the FIFO and line is the reference for every check.
// Define UART_TX_BREAK_EN when compiling to include the break scenario.

module tb_uart_tx_fifo;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n;
  logic              baud_tick;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [3:0]        cfg_data_bits;
  logic [2:0]        cfg_parity;
  logic              cfg_stop2;
  logic              break_req;
  logic              tx;
  logic              tx_busy;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2:0]        state_dbg;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .baud_tick(baud_tick),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx(tx),
    .tx_busy(tx_busy),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] exp_q[$];     // words expected to be waiting in the FIFO
  logic              bits_q[$];    // remaining line bits of the current frame
  logic              line_log[$];  // tx sampled after each tick
  logic              exp_tx;
  logic              exp_busy;
  bit                in_break;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".tx"},         32'(tx),         32'(exp_tx));
    check({where, ".tx_busy"},    32'(tx_busy),    32'(exp_busy));
    check({where, ".fifo_count"}, 32'(fifo_count), 32'(exp_q.size()));
    check({where, ".fifo_full"},  32'(fifo_full),  32'(exp_q.size() == FIFO_DEPTH));
    check({where, ".fifo_empty"}, 32'(fifo_empty), 32'(exp_q.size() == 0));
    check({where, ".s_ready"},    32'(s_ready),    32'(exp_q.size() < FIFO_DEPTH));
  endtask

  function automatic void model_reset();
    exp_q.delete();
    bits_q.delete();
    exp_tx   = 1'b1;
    exp_busy = 1'b0;
    in_break = 0;
  endfunction

  // Build the whole frame for the word at the head of the model FIFO.
  function automatic void model_start_frame();
    logic [DATA_W-1:0] w;
    int                n;
    int                ones;
    w    = exp_q.pop_front();
    n    = ((cfg_data_bits >= 5) && (cfg_data_bits <= DATA_W)) ? int'(cfg_data_bits) : DATA_W;
    ones = 0;
    bits_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits_q.push_back(w[i]);
      ones += int'(w[i]);
    end
    case (cfg_parity)
      3'd1: bits_q.push_back((ones % 2) == 1);
      3'd2: bits_q.push_back((ones % 2) == 0);
      3'd3: bits_q.push_back(1'b1);
      3'd4: bits_q.push_back(1'b0);
      default: ;
    endcase
    bits_q.push_back(1'b1);
    if (cfg_stop2) bits_q.push_back(1'b1);
    exp_tx   = bits_q.pop_front();
    exp_busy = 1'b1;
  endfunction

  // One clock edge of the model. Inputs are the values the DUT sampled at
  // this edge. The tick acts on the old FIFO contents; the write lands after.
  function automatic void model_edge(input logic tick, input logic wr, input logic [DATA_W-1:0] d);
    bit ready;
    bit brk;
    ready = exp_q.size() < FIFO_DEPTH;
`ifdef UART_TX_BREAK_EN
    brk = break_req;
`else
    brk = 0;
`endif
    if (tick) begin
      if (in_break) begin
        if (brk) begin
          exp_tx = 1'b0;
        end else begin
          exp_tx   = 1'b1;
          in_break = 0;
        end
      end else if (bits_q.size() > 0) begin
        exp_tx   = bits_q.pop_front();
        exp_busy = 1'b1;
      end else if (brk) begin
        exp_tx   = 1'b0;
        exp_busy = 1'b1;
        in_break = 1;
      end else if (exp_q.size() > 0) begin
        model_start_frame();
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
    if (wr && ready) exp_q.push_back(d);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic tick, input logic wr, input logic [DATA_W-1:0] d);
    @(negedge clk);
    baud_tick = tick;
    s_valid   = wr;
    s_data    = d;
    @(posedge clk);
    if (reset_n) model_edge(tick, wr, d);
    #1;
    if (tick && reset_n) line_log.push_back(tx);
    check_outputs("cyc");
  endtask

  task automatic run_ticks(input int n, input int div);
    for (int k = 0; k < n; k++) begin
      repeat (div - 1) cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);
    end
  endtask

  task automatic check_seq(input string tag, input int exp_bits[], input int len);
    check({tag, ".len"}, 32'(line_log.size()), 32'(len));
    for (int i = 0; i < len && i < line_log.size(); i++) begin
      check($sformatf("%s.bit%0d", tag, i), 32'(line_log[i]), 32'(exp_bits[i]));
    end
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [2:0] par, input logic st2);
    @(negedge clk);
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = st2;
  endtask

  // ---------------- directed + random sequence ----------------
  int  seq_a5[]  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int  seq_53[]  = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1};
  int  seq_1f[]  = '{0, 1, 1, 1, 1, 1, 0, 1};
  bit  last_tick;
  logic rtick;
  logic rwr;

  initial begin
    reset_n       = 1'b0;
    baud_tick     = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    cfg_data_bits = 4'd8;
    cfg_parity    = 3'd0;
    cfg_stop2     = 1'b0;
    break_req     = 1'b0;
    model_reset();

    // Reset state while reset_n is held low.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 8N1, 0xA5, tick every 16 clocks.
    cycle(1'b0, 1'b1, 8'hA5);
    line_log.delete();
    run_ticks(10, 16);
    check_seq("a5", seq_a5, 10);
    run_ticks(2, 16);

    // 7E2, 0x53.
    set_cfg(4'd7, 3'd1, 1'b1);
    cycle(1'b0, 1'b1, 8'h53);
    line_log.delete();
    run_ticks(11, 4);
    check_seq("e2_53", seq_53, 11);
    run_ticks(2, 4);

    // 5-bit odd, 0x1F. The write shares its cycle with a tick, so the word
    // must wait for the following tick.
    set_cfg(4'd5, 3'd2, 1'b0);
    line_log.delete();
    cycle(1'b1, 1'b1, 8'h1F);
    line_log.delete();
    run_ticks(8, 4);
    check_seq("o5_1f", seq_1f, 8);
    run_ticks(2, 4);

    // A data length of 12 is out of range and falls back to 8 bits.
    set_cfg(4'd12, 3'd3, 1'b0);
    cycle(1'b0, 1'b1, 8'hC6);
    run_ticks(13, 4);

    // Fill the FIFO with no ticks; the 17th write must be dropped.
    set_cfg(4'd8, 3'd0, 1'b0);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      cycle(1'b0, 1'b1, DATA_W'($urandom_range(0, 255)));
    end
    check("fill.full", 32'(fifo_full), 32'd1);
    check("fill.ready", 32'(s_ready), 32'd0);
    run_ticks(FIFO_DEPTH * 10 + 2, 3);

    // Reset during DATA bit 3, with more words queued behind the frame.
    cycle(1'b0, 1'b1, 8'h81);
    cycle(1'b0, 1'b1, 8'h42);
    cycle(1'b0, 1'b1, 8'h24);
    run_ticks(5, 4);
    cycle(1'b0, 1'b0, '0);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_async");
    repeat (3) cycle(1'b0, 1'b0, '0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, 8'h3C);
    run_ticks(12, 4);

`ifdef UART_TX_BREAK_EN
    // A break with a word waiting: 20 low ticks, a mark, then the frame.
    @(negedge clk);
    break_req = 1'b1;
    cycle(1'b0, 1'b1, 8'h96);
    line_log.delete();
    run_ticks(20, 4);
    @(negedge clk);
    break_req = 1'b0;
    run_ticks(13, 4);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("brk.low%0d", i), 32'(line_log[i]), 32'd0);
    end
    check("brk.mark", 32'(line_log[20]), 32'd1);
    check("brk.start", 32'(line_log[21]), 32'd0);
`endif

    // Randomized soak: mixed writes, sparse ticks, config changes mid-frame.
    last_tick = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        cfg_data_bits = 4'($urandom_range(0, 15));
        cfg_parity    = 3'($urandom_range(0, 7));
        cfg_stop2     = 1'($urandom_range(0, 1));
      end
`ifdef UART_TX_BREAK_EN
      if ($urandom_range(0, 299) == 0) break_req = ~break_req;
`endif
      rtick = !last_tick && ($urandom_range(0, 3) == 0);
      rwr   = ($urandom_range(0, 4) == 0);
      cycle(rtick, rwr, DATA_W'($urandom));
      last_tick = rtick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
